// File: rtl/fan_pwm_drive.sv
// Fan PWM driver: 1024-cycle PWM with stopped-fan kick start and slew-limited duty.
// Latency: speed is sampled at the cnt==1023 edge; the new duty applies from cnt==0.
// Backpressure: none; speed is a level input and is only looked at once per period.
module fan_pwm_drive #(
    parameter int STEP         = 16,
    parameter int KICK_PERIODS = 4,   // 1..256
    parameter int MIN_DUTY     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] speed,
    output logic       pwm_out,
    output logic [9:0] duty,
    output logic [1:0] state,
    output logic       period_start
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] MIN_W    = 11'(MIN_DUTY);
    localparam logic [7:0]  KICK_LD  = 8'(KICK_PERIODS - 1);
    localparam logic [9:0]  FULL     = 10'd1023;

    logic [9:0]  cnt;
    state_t      st, st_nxt;
    logic [9:0]  duty_nxt;
    logic [7:0]  kcnt, kcnt_nxt;
    logic [9:0]  target;
    logic [10:0] diff_up, diff_dn;
    logic [9:0]  slewed;
    logic        boundary;

    assign boundary     = (cnt == 10'd1023);
    assign target       = ({1'b0, speed} < MIN_W) ? 10'd0 : speed;
    assign diff_up      = {1'b0, target} - {1'b0, duty};
    assign diff_dn      = {1'b0, duty} - {1'b0, target};

    // Both outputs decode straight from registered cnt/duty, so no glitchy input paths.
    assign pwm_out      = (cnt < duty);
    assign period_start = (cnt == 10'd0);
    assign state        = st;

    // Slew one step toward target; the compare against the 11-bit distance keeps duty in range.
    always_comb begin
        slewed = duty;
        if (target > duty) begin
            slewed = (diff_up > STEP_W) ? (duty + STEP_W[9:0]) : target;
        end else if (target < duty) begin
            slewed = (diff_dn > STEP_W) ? (duty - STEP_W[9:0]) : target;
        end
    end

    // Free-running period counter plus the per-period control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 10'd0;
            st   <= IDLE;
            duty <= 10'd0;
            kcnt <= 8'd0;
        end else begin
            cnt  <= cnt + 10'd1;
            st   <= st_nxt;
            duty <= duty_nxt;
            kcnt <= kcnt_nxt;
        end
    end

    // Next-state and duty decisions, taken only at the period boundary.
    always_comb begin
        st_nxt   = st;
        duty_nxt = duty;
        kcnt_nxt = kcnt;
        if (boundary) begin
            case (st)
                IDLE: begin
                    if (target != 10'd0) begin
                        st_nxt   = KICK;
                        duty_nxt = FULL;
                        kcnt_nxt = KICK_LD;
                    end else begin
                        duty_nxt = 10'd0;
                    end
                end
                KICK: begin
                    if (kcnt != 8'd0) begin
                        kcnt_nxt = kcnt - 8'd1;
                        duty_nxt = FULL;
                    end else if (target == 10'd0) begin
                        st_nxt   = IDLE;
                        duty_nxt = 10'd0;
                    end else begin
                        // Fan is spinning now, so jump straight to the requested duty.
                        st_nxt   = RUN;
                        duty_nxt = target;
                    end
                end
                RUN: begin
                    duty_nxt = slewed;
                    if (slewed == 10'd0 && target == 10'd0) begin
                        st_nxt = IDLE;
                    end
                end
                default: begin
                    st_nxt   = IDLE;
                    duty_nxt = 10'd0;
                    kcnt_nxt = 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fan_pwm_drive.sv
// Bench for fan_pwm_drive: period-level reference model, random and scripted speeds.
// Latency: the model updates once per 1024-cycle period, at the cnt==1023 edge.
// Backpressure: none.
module tb_fan_pwm_drive;

    localparam int STEP = 16;
    localparam int KICK = 4;
    localparam int MIND = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] speed = 10'd0;
    logic       pwm_out;
    logic [9:0] duty;
    logic [1:0] state;
    logic       period_start;

    int errors = 0;
    int checks = 0;

    // Reference model: duty/state applied during the current period, kick periods elapsed.
    int m_duty  = 0;
    int m_state = 0;
    int m_kdone = 0;

    fan_pwm_drive #(.STEP(STEP), .KICK_PERIODS(KICK), .MIN_DUTY(MIND)) dut (
        .clk          (clk),
        .rst          (rst),
        .speed        (speed),
        .pwm_out      (pwm_out),
        .duty         (duty),
        .state        (state),
        .period_start (period_start)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Period-level behaviour: what the fan should see in the next period given speed now.
    task automatic model_boundary(input int spd);
        int tgt;
        tgt = (spd < MIND) ? 0 : spd;
        if (m_state == 0) begin
            if (tgt != 0) begin
                m_state = 1;
                m_duty  = 1023;
                m_kdone = 0;
            end else begin
                m_duty = 0;
            end
        end else if (m_state == 1) begin
            m_kdone++;
            if (m_kdone == KICK) begin
                m_state = (tgt == 0) ? 0 : 2;
                m_duty  = tgt;
            end
        end else begin
            if (tgt > m_duty)
                m_duty = (m_duty + STEP < tgt) ? m_duty + STEP : tgt;
            else
                m_duty = (m_duty - STEP > tgt) ? m_duty - STEP : tgt;
            if (m_duty == 0 && tgt == 0)
                m_state = 0;
        end
    endtask

    // Assert reset, confirm the outputs drop at once, hold, release on a falling edge.
    task automatic do_reset(input int hold);
        rst = 1'b1;
        #1;
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_duty", 32'(duty), 0);
        check("rst_state", 32'(state), 0);
        check("rst_pstart", 32'(period_start), 1);
        m_duty  = 0;
        m_state = 0;
        m_kdone = 0;
        repeat (hold) @(negedge clk);
        rst = 1'b0;
    endtask

    // One PWM period, entered on the falling edge where cnt==0.
    // spd<0 draws random speeds; noise adds mid-period speed changes; rst_at<0 disables reset.
    task automatic run_period(input int spd, input bit noise, input int rst_at);
        int hi;
        int ps;
        int pd;
        int cur;
        hi = 0;
        ps = 0;
        pd = m_duty;
        for (int c = 0; c < 1024; c++) begin
            if (c == 0) begin
                check("duty", 32'(duty), 32'(m_duty));
                check("state", 32'(state), 32'(m_state));
            end
            hi += int'(pwm_out);
            ps += int'(period_start);
            if (c == rst_at) begin
                do_reset(3);
                return;
            end
            cur = (spd >= 0) ? spd : int'($urandom_range(0, 1023));
            if (c == 0)
                speed = 10'(cur);
            if (noise && (c == 300 || c == 700))
                speed = 10'($urandom_range(0, 1023));
            if (noise && c == 1021)
                speed = 10'(cur);
            if (c == 1023)
                model_boundary(int'(speed));
            @(negedge clk);
        end
        check("pwm_high", 32'(hi), 32'(pd));
        check("pstart_cnt", 32'(ps), 1);
    endtask

    initial begin
        do_reset(3);

        // Fan off: no drive at all for ten periods.
        repeat (10) run_period(0, 1'b0, -1);

        // Kick from stop, then settle at 512, then slew up to 600.
        repeat (6) run_period(512, 1'b0, -1);
        repeat (8) run_period(600, 1'b0, -1);

        // Fresh start at 100, ramp down, recover mid-ramp, then ramp fully to stop.
        do_reset(2);
        repeat (6) run_period(100, 1'b0, -1);
        repeat (3) run_period(30, 1'b0, -1);
        repeat (3) run_period(200, 1'b0, -1);
        repeat (8) run_period(30, 1'b0, -1);

        // Reset during the second kick period, then a complete fresh kick.
        run_period(512, 1'b0, -1);
        run_period(512, 1'b0, -1);
        run_period(512, 1'b0, 500);
        repeat (6) run_period(512, 1'b0, -1);

        // Mid-period speed changes must be ignored at the fixed setpoint.
        repeat (3) run_period(512, 1'b1, -1);

        // Fully random speeds, including values below the fan-off threshold.
        repeat (12) run_period(-1, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fan_pwm_drive.md
FAN_PWM_DRIVE -- requirements
Module: fan_pwm_drive

Interface
REQ-001 SHALL have parameter STEP, default 16, giving the maximum duty change per PWM period in RUN.
REQ-002 SHALL have parameter KICK_PERIODS, default 4, giving the number of full-duty periods used to spin up a stopped fan.
REQ-003 SHALL have parameter MIN_DUTY, default 64; any requested speed below this is treated as fan-off.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port speed, input, 10 bits: requested duty, i.e. the cooler controller speed output, unsigned 0..1023.
REQ-007 SHALL have port pwm_out, output, 1 bit: fan PWM drive.
REQ-008 SHALL have port duty, output, 10 bits: currently applied duty.
REQ-009 SHALL have port state, output, 2 bits: IDLE=0, KICK=1, RUN=2; 3 is unused.
REQ-010 SHALL have port period_start, output, 1 bit: high for one cycle whenever the period counter equals 0.

Function
REQ-011 SHALL run a free-running 10-bit period counter cnt, incrementing every clk and wrapping 1023->0; PWM period is 1024 cycles.
REQ-012 SHALL drive pwm_out = (cnt < duty), decoded only from registers; duty 0 gives constant low, duty 1023 gives high for 1023 of 1024 cycles.
REQ-013 SHALL sample speed only on the clk edge where cnt==1023 (the period boundary); duty and state change only at that edge and take effect from cnt==0.
REQ-014 SHALL form target = 0 if speed < MIN_DUTY, otherwise target = speed.
REQ-015 SHALL ignore speed changes between boundaries; no mid-period duty change is permitted.
REQ-016 IDLE: duty=0; at a boundary with target!=0, SHALL go to KICK, set duty=1023 and load the kick counter with KICK_PERIODS-1.
REQ-017 IDLE: at a boundary with target==0, SHALL remain in IDLE with duty=0.
REQ-018 KICK: at each boundary with the kick counter !=0, SHALL decrement the counter and hold duty=1023 whatever target is.
REQ-019 KICK: at the boundary with the kick counter ==0, SHALL go to RUN with duty=target loaded directly (no slew), or go to IDLE with duty=0 if target==0.
REQ-020 RUN: at each boundary, SHALL update duty by +min(STEP, target-duty) if target>duty, by -min(STEP, duty-target) if target<duty, and leave it unchanged if equal.
REQ-021 RUN: SHALL go to IDLE at the boundary where the newly computed duty is 0 and target==0; a target rising to >=MIN_DUTY during ramp-down SHALL stay in RUN with no kick.
REQ-022 Arithmetic SHALL be done at 11 bits or with an explicit compare so duty never wraps below 0 or above 1023.
REQ-023 SHALL decode state value 3 as IDLE at the next boundary, with duty forced to 0.

Reset
REQ-024 While rst=1, SHALL set cnt=0, duty=0, state=IDLE, kick counter=0, pwm_out=0 and period_start=1 (since cnt==0), asynchronously and irrespective of clk.
REQ-025 After rst falls, SHALL begin counting on the first rising clk edge, with the first boundary at cnt==1023.
REQ-026 Reset asserted mid-KICK or mid-RUN SHALL abort immediately to the reset values; no kick resumes.

Verification (clk 20 ns, default parameters)
REQ-027 speed=0 for 10 periods after reset -> pwm_out stays 0, state=0, period_start pulses every 1024 cycles.
REQ-028 speed=512 set before the first boundary -> state=1 with duty=1023 for 4 periods, then state=2 with duty=512; pwm_out high for 512 cycles per period.
REQ-029 In RUN at duty 512, speed->600 -> duty at successive boundaries 528,544,560,576,592,600, then holds.
REQ-030 In RUN at duty 100, speed->30 -> duty 84,68,52,36,20,4,0 with state->0 at the duty=0 boundary; speed->200 while at duty 52 -> duty climbs by 16 per period from 52 with state staying 2.
REQ-031 speed toggled 512->700->512 within one period -> duty unchanged until the boundary, then uses the value present at cnt==1023.
REQ-032 rst pulsed for 3 cycles during the 2nd KICK period -> pwm_out, duty and state go to 0 immediately; with speed=512 held, a fresh 4-period kick follows the next boundary.
